// File: rtl/bc_drive_route.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bc_drive_route                                                |
// | Purpose  : Bus-connect datapath for the program sequencer. Captures the  |
// |            source operand into the bus data register (DRR), delivers the |
// |            destination operand (DM read data, DRR or immediate) to the   |
// |            write-back side, runs the DM-write req/ack handshake and      |
// |            raises a stall while a DM access is outstanding.              |
// | Ports    : clk, rst_n (async, active-low)                                |
// |            ps_bc_drr_slct, ps_bc_di_slct, ps_dm_wr, ps_imm  - sequencer  |
// |            xb_dt, ps_stk_dt, dg_dt                          - DRR srcs   |
// |            dm_rd_dt, dm_rd_vld, dm_wr_ack                   - DM side    |
// |            bc_dm_wr_req, bc_dm_wr_dt                        - DM write   |
// |            bc_dt, bc_dt_vld, bc_stall                       - results    |
// | Config   : BC_OUT_REG_EN - register bc_dt / bc_dt_vld (one extra cycle)  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module bc_drive_route #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    ps_bc_drr_slct,
  input  logic [1:0]    ps_bc_di_slct,
  input  logic          ps_dm_wr,
  input  logic [DW-1:0] ps_imm,
  input  logic [DW-1:0] xb_dt,
  input  logic [DW-1:0] ps_stk_dt,
  input  logic [DW-1:0] dg_dt,
  input  logic [DW-1:0] dm_rd_dt,
  input  logic          dm_rd_vld,
  input  logic          dm_wr_ack,
  output logic          bc_dm_wr_req,
  output logic [DW-1:0] bc_dm_wr_dt,
  output logic [DW-1:0] bc_dt,
  output logic          bc_dt_vld,
  output logic          bc_stall
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_t;

  state_t        state;
  logic [DW-1:0] drr_reg;
  logic [DW-1:0] imm_reg;
  logic          wr_pend;

  // Operation in flight this cycle: a wait state owns the operation it
  // latched on entry, otherwise it is decoded fresh from the issue select.
  logic op_rd;
  logic op_wr;
  logic op_xfer;
  logic op_imm;

  always_comb begin
    op_rd   = 1'b0;
    op_wr   = 1'b0;
    op_xfer = 1'b0;
    op_imm  = 1'b0;
    case (state)
      IDLE: begin
        case (ps_bc_di_slct)
          2'b00:   op_rd = 1'b1;
          2'b01: begin
            op_wr   = wr_pend;
            op_xfer = ~wr_pend;
          end
          2'b10:   op_imm = 1'b1;
          default: ;
        endcase
      end
      RD_WAIT: op_rd = 1'b1;
      WR_WAIT: op_wr = 1'b1;
      default: ;
    endcase
  end

  logic          stall;
  logic          dt_vld_c;
  logic [DW-1:0] dt_c;

  // Outputs are forced low while reset is held so nothing escapes the
  // combinational issue decode during reset.
  assign stall    = rst_n & ((op_rd & ~dm_rd_vld) | (op_wr & ~dm_wr_ack));
  assign dt_vld_c = rst_n & ((op_rd & dm_rd_vld) | op_xfer | op_imm);

  always_comb begin
    dt_c = '0;
    if (dt_vld_c) begin
      if (op_rd)        dt_c = dm_rd_dt;
      else if (op_xfer) dt_c = drr_reg;
      else              dt_c = imm_reg;
    end
  end

  assign bc_stall     = stall;
  assign bc_dm_wr_req = rst_n & op_wr;
  assign bc_dm_wr_dt  = rst_n ? drr_reg : '0;

  // Single sequential block: FSM plus capture stage. Capture is frozen while
  // stalled, which also keeps drr_reg (the write data) stable in WR_WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      drr_reg <= '0;
      imm_reg <= '0;
      wr_pend <= 1'b0;
    end else begin
      if (stall) state <= op_rd ? RD_WAIT : WR_WAIT;
      else       state <= IDLE;

      if (!stall) begin
        case (ps_bc_drr_slct)
          2'b00:   drr_reg <= xb_dt;
          2'b01:   drr_reg <= ps_stk_dt;
          2'b10:   drr_reg <= dg_dt;
          default: drr_reg <= drr_reg;
        endcase
        imm_reg <= ps_imm;
        wr_pend <= ps_dm_wr;
      end
    end
  end

`ifdef BC_OUT_REG_EN
  logic [DW-1:0] dt_q;
  logic          dt_vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dt_q     <= '0;
      dt_vld_q <= 1'b0;
    end else begin
      dt_q     <= dt_c;
      dt_vld_q <= dt_vld_c;
    end
  end

  assign bc_dt     = dt_q;
  assign bc_dt_vld = dt_vld_q;
`else
  assign bc_dt     = dt_c;
  assign bc_dt_vld = dt_vld_c;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bc_drive_route.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_bc_drive_route                                             |
// | Purpose  : Self-checking bench for bc_drive_route: an operation-level    |
// |            reference model checked every cycle plus directed scenarios  |
// |            with literal expectations read from a per-cycle output log.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_bc_drive_route;

  localparam int DW = 16;
`ifdef BC_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk;
  logic          rst_n;
  logic [1:0]    ps_bc_drr_slct;
  logic [1:0]    ps_bc_di_slct;
  logic          ps_dm_wr;
  logic [DW-1:0] ps_imm;
  logic [DW-1:0] xb_dt;
  logic [DW-1:0] ps_stk_dt;
  logic [DW-1:0] dg_dt;
  logic [DW-1:0] dm_rd_dt;
  logic          dm_rd_vld;
  logic          dm_wr_ack;
  logic          bc_dm_wr_req;
  logic [DW-1:0] bc_dm_wr_dt;
  logic [DW-1:0] bc_dt;
  logic          bc_dt_vld;
  logic          bc_stall;

  bc_drive_route #(.DW(DW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ps_bc_drr_slct (ps_bc_drr_slct),
    .ps_bc_di_slct  (ps_bc_di_slct),
    .ps_dm_wr       (ps_dm_wr),
    .ps_imm         (ps_imm),
    .xb_dt          (xb_dt),
    .ps_stk_dt      (ps_stk_dt),
    .dg_dt          (dg_dt),
    .dm_rd_dt       (dm_rd_dt),
    .dm_rd_vld      (dm_rd_vld),
    .dm_wr_ack      (dm_wr_ack),
    .bc_dm_wr_req   (bc_dm_wr_req),
    .bc_dm_wr_dt    (bc_dm_wr_dt),
    .bc_dt          (bc_dt),
    .bc_dt_vld      (bc_dt_vld),
    .bc_stall       (bc_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle log of observed outputs, indexed by cycle number.
  bit            log_vld   [0:511];
  bit            log_stall [0:511];
  bit            log_req   [0:511];
  logic [DW-1:0] log_dt    [0:511];
  logic [DW-1:0] log_wdt   [0:511];

  // Reference model: tracks the outstanding DM operation and the captured
  // operands; the current operation is either the outstanding one or the
  // newly issued one.
  localparam int OP_NONE = 0, OP_RD = 1, OP_WR = 2, OP_XFER = 3, OP_IMM = 4;
  logic [DW-1:0] m_drr = '0, m_imm = '0, m_prev_dt = '0;
  bit            m_wr = 0, m_prev_vld = 0;
  int            m_pend = OP_NONE;

  always @(negedge clk) begin
    int            op;
    bit            e_stall, e_req, e_vld, c_vld;
    logic [DW-1:0] e_dt, c_dt;
    if (cyc < 512) begin
      log_vld[cyc]   = bc_dt_vld;
      log_stall[cyc] = bc_stall;
      log_req[cyc]   = bc_dm_wr_req;
      log_dt[cyc]    = bc_dt;
      log_wdt[cyc]   = bc_dm_wr_dt;
    end
    if (!rst_n) begin
      chk("rst_stall", {31'd0, bc_stall}, 32'd0);
      chk("rst_req",   {31'd0, bc_dm_wr_req}, 32'd0);
      chk("rst_vld",   {31'd0, bc_dt_vld}, 32'd0);
      chk("rst_dt",    {16'd0, bc_dt}, 32'd0);
      chk("rst_wdt",   {16'd0, bc_dm_wr_dt}, 32'd0);
      m_drr = '0; m_imm = '0; m_wr = 0; m_pend = OP_NONE;
      m_prev_vld = 0; m_prev_dt = '0;
    end else begin
      if (m_pend != OP_NONE) op = m_pend;
      else if (ps_bc_di_slct == 2'b00) op = OP_RD;
      else if (ps_bc_di_slct == 2'b01) op = m_wr ? OP_WR : OP_XFER;
      else if (ps_bc_di_slct == 2'b10) op = OP_IMM;
      else op = OP_NONE;

      e_stall = (op == OP_RD && !dm_rd_vld) || (op == OP_WR && !dm_wr_ack);
      e_req   = (op == OP_WR);
      c_vld   = (op == OP_RD && dm_rd_vld) || op == OP_XFER || op == OP_IMM;
      c_dt    = (op == OP_RD) ? dm_rd_dt : (op == OP_XFER) ? m_drr : m_imm;
`ifdef BC_OUT_REG_EN
      e_vld = m_prev_vld;
      e_dt  = m_prev_dt;
`else
      e_vld = c_vld;
      e_dt  = c_dt;
`endif
      chk("cyc_stall", {31'd0, bc_stall}, {31'd0, e_stall});
      chk("cyc_req",   {31'd0, bc_dm_wr_req}, {31'd0, e_req});
      chk("cyc_vld",   {31'd0, bc_dt_vld}, {31'd0, e_vld});
      if (e_req) chk("cyc_wdt", {16'd0, bc_dm_wr_dt}, {16'd0, m_drr});
      if (e_vld) chk("cyc_dt",  {16'd0, bc_dt}, {16'd0, e_dt});

      m_prev_vld = c_vld;
      m_prev_dt  = c_dt;
      m_pend     = e_stall ? op : OP_NONE;
      if (!e_stall) begin
        if (ps_bc_drr_slct == 2'b00)      m_drr = xb_dt;
        else if (ps_bc_drr_slct == 2'b01) m_drr = ps_stk_dt;
        else if (ps_bc_drr_slct == 2'b10) m_drr = dg_dt;
        m_imm = ps_imm;
        m_wr  = ps_dm_wr;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n, r, req_cnt, stall_cnt, vld_cnt;
    rst_n = 0; ps_bc_drr_slct = 2'b11; ps_bc_di_slct = 2'b11; ps_dm_wr = 0;
    ps_imm = '0; xb_dt = '0; ps_stk_dt = 16'h7777; dg_dt = '0;
    dm_rd_dt = '0; dm_rd_vld = 0; dm_wr_ack = 0;
    step(); step();
    // Reset state with an issue select that would otherwise produce output.
    ps_bc_di_slct = 2'b10; #1;
    chk("reset_vld", {31'd0, bc_dt_vld}, 32'd0);
    chk("reset_req", {31'd0, bc_dm_wr_req}, 32'd0);
    ps_bc_di_slct = 2'b11;
    step();
    rst_n = 1;
    step();

    // 1: DRR <- xb, transfer to bc_dt.
    ps_bc_drr_slct = 2'b00; xb_dt = 16'h1234; ps_dm_wr = 0; ps_bc_di_slct = 2'b11;
    n = cyc;
    step(); ps_bc_drr_slct = 2'b11; ps_bc_di_slct = 2'b01;
    step(); ps_bc_di_slct = 2'b11;
    step(); step();
    chk("s1_vld",      {31'd0, log_vld[n+LAT]}, 32'd1);
    chk("s1_dt",       {16'd0, log_dt[n+LAT]}, 32'h1234);
    chk("s1_vld_pre",  {31'd0, log_vld[n+LAT-1]}, 32'd0);
    chk("s1_stall",    {31'd0, log_stall[n+1]}, 32'd0);

    // 2: DM write of DAG data, ack after 3 wait cycles.
    ps_bc_drr_slct = 2'b10; dg_dt = 16'hBEEF; ps_dm_wr = 1; ps_bc_di_slct = 2'b11;
    n = cyc;
    step(); ps_bc_drr_slct = 2'b11; ps_dm_wr = 0; ps_bc_di_slct = 2'b01; dm_wr_ack = 0;
    step(); step(); step(); dm_wr_ack = 1;
    step(); dm_wr_ack = 0; ps_bc_di_slct = 2'b11;
    step(); step();
    req_cnt = 0; stall_cnt = 0; vld_cnt = 0;
    for (int i = n + 1; i <= n + 6; i++) begin
      req_cnt   += int'(log_req[i]);
      stall_cnt += int'(log_stall[i]);
      vld_cnt   += int'(log_vld[i]);
    end
    chk("s2_req_cycles",   req_cnt, 4);
    chk("s2_stall_cycles", stall_cnt, 3);
    chk("s2_vld_cycles",   vld_cnt, 0);
    chk("s2_wdt_first",    {16'd0, log_wdt[n+1]}, 32'hBEEF);
    chk("s2_wdt_ack",      {16'd0, log_wdt[n+4]}, 32'hBEEF);
    chk("s2_req_after",    {31'd0, log_req[n+5]}, 32'd0);

    // 3: immediate, then DRR transfer shows DRR untouched by code 11.
    ps_bc_drr_slct = 2'b11; ps_imm = 16'h00A5; ps_dm_wr = 0; ps_bc_di_slct = 2'b11;
    n = cyc;
    step(); ps_bc_di_slct = 2'b10; ps_imm = 16'h0000;
    step(); ps_bc_di_slct = 2'b01;
    step(); ps_bc_di_slct = 2'b11;
    step(); step();
    chk("s3_imm_vld", {31'd0, log_vld[n+LAT]}, 32'd1);
    chk("s3_imm_dt",  {16'd0, log_dt[n+LAT]}, 32'h00A5);
    chk("s3_drr_vld", {31'd0, log_vld[n+1+LAT]}, 32'd1);
    chk("s3_drr_dt",  {16'd0, log_dt[n+1+LAT]}, 32'hBEEF);

    // 4: DM read with two wait cycles.
    ps_bc_di_slct = 2'b11;
    n = cyc;
    step(); ps_bc_di_slct = 2'b00; dm_rd_vld = 0;
    step();
    step(); dm_rd_vld = 1; dm_rd_dt = 16'h5A5A;
    step(); dm_rd_vld = 0; dm_rd_dt = 16'h0000; ps_bc_di_slct = 2'b11;
    step(); step();
    vld_cnt = 0;
    for (int i = n; i <= n + 5; i++) vld_cnt += int'(log_vld[i]);
    chk("s4_stall1",   {31'd0, log_stall[n+1]}, 32'd1);
    chk("s4_stall2",   {31'd0, log_stall[n+2]}, 32'd1);
    chk("s4_stall3",   {31'd0, log_stall[n+3]}, 32'd0);
    chk("s4_vld_once", vld_cnt, 1);
    chk("s4_vld",      {31'd0, log_vld[n+2+LAT]}, 32'd1);
    chk("s4_dt",       {16'd0, log_dt[n+2+LAT]}, 32'h5A5A);

    // 6: back-to-back zero-wait writes, then stray ack/read-valid while idle.
    ps_bc_drr_slct = 2'b00; xb_dt = 16'h1111; ps_dm_wr = 1; ps_bc_di_slct = 2'b11;
    n = cyc;
    step(); ps_bc_di_slct = 2'b01; dm_wr_ack = 1; xb_dt = 16'h2222;
    step(); ps_bc_drr_slct = 2'b11; ps_dm_wr = 0;
    step(); ps_bc_di_slct = 2'b11; dm_rd_vld = 1;
    step(); dm_wr_ack = 0; dm_rd_vld = 0;
    step(); step();
    chk("s6_req1",    {31'd0, log_req[n+1]}, 32'd1);
    chk("s6_wdt1",    {16'd0, log_wdt[n+1]}, 32'h1111);
    chk("s6_req2",    {31'd0, log_req[n+2]}, 32'd1);
    chk("s6_wdt2",    {16'd0, log_wdt[n+2]}, 32'h2222);
    chk("s6_stall",   {30'd0, log_stall[n+1], log_stall[n+2]}, 32'd0);
    chk("s6_req_end", {31'd0, log_req[n+3]}, 32'd0);
    chk("s6_stray",   {30'd0, log_vld[n+LAT+2], log_stall[n+3]}, 32'd0);

    // 5: reset during WR_WAIT, then a late ack must be ignored.
    ps_bc_drr_slct = 2'b00; xb_dt = 16'hCAFE; ps_dm_wr = 1; ps_bc_di_slct = 2'b11;
    step(); ps_bc_drr_slct = 2'b11; ps_dm_wr = 0; ps_bc_di_slct = 2'b01; dm_wr_ack = 0;
    step();
    @(negedge clk);
    chk("s5_in_wait", {30'd0, bc_dm_wr_req, bc_stall}, 32'd3);
    #1 rst_n = 0;
    #1;
    chk("s5_req_rst", {31'd0, bc_dm_wr_req}, 32'd0);
    step(); ps_bc_di_slct = 2'b11;
    step(); rst_n = 1; dm_wr_ack = 1;
    r = cyc;
    step(); dm_wr_ack = 0; ps_bc_di_slct = 2'b01;
    step(); ps_bc_di_slct = 2'b11;
    step(); step();
    chk("s5_late_ack", {29'd0, log_req[r], log_stall[r], log_vld[r]}, 32'd0);
    chk("s5_drr_vld",  {31'd0, log_vld[r+LAT]}, 32'd1);
    chk("s5_drr_zero", {16'd0, log_dt[r+LAT]}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bc_drive_route.md
# bc_drive_route

Bus-connect datapath for the program sequencer. Consumes the select codes `ps_bc_drr_slct` / `ps_bc_di_slct` and routes the actual data:
- captures the source operand into the bus data register (DRR);
- delivers the destination operand (DM read data, DRR, or immediate) to the write-back side;
- runs the DM-write request/acknowledge handshake.

It raises a stall toward the sequencer while a DM access is outstanding.

## Interface
- `DW`, default 16, width of all data paths.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ps_bc_drr_slct`  in  2  DRR source select, valid cycle N: 00 compute reg file, 01 PS stack/status, 10 DAG, 11 no capture.
- `ps_bc_di_slct`  in  2  destination select, registered upstream, valid cycle N+1: 00 DM read data, 01 DRR, 10 immediate, 11 none.
- `ps_dm_wr`  in  1  cycle N: current instruction is a DM write.
- `ps_imm`  in  DW  cycle N immediate operand.
- `xb_dt`, `ps_stk_dt`, `dg_dt`  in  DW each  DRR sources for codes 00/01/10.
- `dm_rd_dt`  in  DW  DM read data.
- `dm_rd_vld`  in  1  DM read data valid.
- `dm_wr_ack`  in  1  DM write accepted.
- `bc_dm_wr_req`  out  1  DM write request.
- `bc_dm_wr_dt`  out  DW  DM write data.
- `bc_dt`  out  DW  destination data.
- `bc_dt_vld`  out  1  destination data valid strobe.
- `bc_stall`  out  1  sequencer freeze request.

## Operation
**Capture stage (cycle N, only when `bc_stall`=0):**
- `drr_reg` <= source selected by `ps_bc_drr_slct`. Code 11 holds `drr_reg`.
- `imm_reg` <= `ps_imm`.
- `wr_pend` <= `ps_dm_wr`.

**Issue stage (cycle N+1, state IDLE), decoded from `ps_bc_di_slct`:**
- 01 with `wr_pend`=1:
  - `bc_dm_wr_req`=1, `bc_dm_wr_dt`=`drr_reg`, `bc_dt_vld`=0.
  - If `dm_wr_ack`=0, go to WR_WAIT.
- 01 with `wr_pend`=0:
  - `bc_dt`=`drr_reg`, `bc_dt_vld`=1. Covers register transfer and stack push.
- 00:
  - If `dm_rd_vld`=1: `bc_dt`=`dm_rd_dt`, `bc_dt_vld`=1.
  - Else go to RD_WAIT.
- 10: `bc_dt`=`imm_reg`, `bc_dt_vld`=1.
- 11: no output activity. `wr_pend` is ignored.

**FSM (IDLE, RD_WAIT, WR_WAIT):**
- RD_WAIT: stays until `dm_rd_vld`=1. On that cycle `bc_dt`=`dm_rd_dt`, `bc_dt_vld`=1, then IDLE.
- WR_WAIT: `bc_dm_wr_req` and `bc_dm_wr_dt` held stable until `dm_wr_ack`=1. The request deasserts the cycle after the ack; the FSM goes to IDLE.
- While in RD_WAIT or WR_WAIT, `ps_bc_di_slct`, `ps_bc_drr_slct` and `ps_dm_wr` are ignored. The operation is latched internally on entry.

**`bc_stall`** (combinational):
- (IDLE, di=00, !`dm_rd_vld`) | (IDLE, di=01, `wr_pend`, !`dm_wr_ack`)
- | (RD_WAIT, !`dm_rd_vld`) | (WR_WAIT, !`dm_wr_ack`).

**Sequencer contract:** the sequencer freezes its pipeline while `bc_stall`=1, so `ps_bc_di_slct` is stable on the release cycle.

**Boundary conditions:**
- `dm_rd_vld` or `dm_wr_ack` asserted while no access is pending: ignored.
- `dm_wr_ack` in the same cycle as the request: completes with zero wait and no stall.
- Back-to-back DM writes: one request per instruction. `bc_dm_wr_req` may stay high across consecutive acked writes.

## Timing
- **Reset (`rst_n` low, async):**
  - Outputs: all 0.
  - Registers: `drr_reg`=0, `imm_reg`=0, `wr_pend`=0, latched di=11.
  - FSM: IDLE.
- **Reset mid-operation:** any wait state is abandoned immediately, with no request or valid strobe after release.
- **Latency, no wait states:**
  - DRR source sampled at edge N.
  - `bc_dt` / `bc_dm_wr_dt` valid during cycle N+1.
- **Read wait:** `bc_dt_vld` asserts in the first cycle in which `dm_rd_vld`=1.
- **Valid strobe:** `bc_dt_vld` is a single-cycle pulse per instruction. `bc_dt` may hold its previous value when `bc_dt_vld`=0.

## Configuration
- **`BC_OUT_REG_EN` defined:**
  - `bc_dt` and `bc_dt_vld` are registered, adding one cycle: valid N+2, or the cycle after `dm_rd_vld`.
  - `bc_stall` and the DM write outputs are unchanged.
  - The output register resets to 0.
- **Undefined:** `bc_dt` / `bc_dt_vld` are combinational from the issue stage, as described above.

## Test plan
- drr=00, `xb_dt`=0x1234, next cycle di=01, `ps_dm_wr`=0 -> `bc_dt`=0x1234, `bc_dt_vld`=1 in cycle N+1, `bc_stall`=0.
- drr=10, `dg_dt`=0xBEEF, `ps_dm_wr`=1, di=01, `dm_wr_ack` delayed 3 cycles -> `bc_dm_wr_req`=1 with `bc_dm_wr_dt`=0xBEEF for 4 cycles, `bc_stall`=1 for 3 cycles, `bc_dt_vld` never 1.
- drr=11, `ps_imm`=0x00A5, di=10 -> `bc_dt`=0x00A5 valid in N+1, `drr_reg` unchanged.
- di=00 with `dm_rd_vld` low 2 cycles, then high with `dm_rd_dt`=0x5A5A -> `bc_stall`=1 for 2 cycles, single `bc_dt_vld` pulse with 0x5A5A.
- `rst_n` pulsed low during WR_WAIT -> `bc_dm_wr_req`=0 immediately, FSM IDLE, a later `dm_wr_ack` is ignored.
- With `BC_OUT_REG_EN`, repeat scenario 1 -> `bc_dt`=0x1234 valid in cycle N+2.
